// File: rtl/sp_bram_arb.sv
// Two-requester round-robin arbiter in front of a single-port block RAM, one-cycle read latency.
// Define SP_BRAM_ARB_CLEAR_EN to compile in the post-reset clear sweep that zeroes the array.

module sp_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1<<ADDR_WIDTH)-1];

  // Write-first port: a write returns the new word on q.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= d;
      q           <= d;
    end else begin
      q <= mem_r[addr];
    end
  end

endmodule

module sp_bram_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  a_valid,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  a_resp_valid,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy
);

  logic                  run_s;
  logic                  clr_we_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  prio_r;
  logic                  a_resp_valid_r;
  logic                  b_resp_valid_r;
  logic [ADDR_WIDTH-1:0] last_addr_r;
  logic                  ram_we_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [DATA_WIDTH-1:0] ram_d_s;
  logic [DATA_WIDTH-1:0] ram_q_s;

`ifdef SP_BRAM_ARB_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] clr_addr_r;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sweep address counter; wraps back to 0 as the sweep finishes.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      clr_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      clr_addr_r <= clr_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      clr_addr_r <= {ADDR_WIDTH{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_addr_r == CLR_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    run_s      = 1'b0;
    clr_we_s   = 1'b0;
    clr_addr_s = clr_addr_r;
    case (state_r)
      ST_CLEAR: clr_we_s = 1'b1;
      ST_RUN:   run_s    = 1'b1;
      default: begin
        run_s    = 1'b0;
        clr_we_s = 1'b0;
      end
    endcase
  end
`else
  assign run_s      = 1'b1;
  assign clr_we_s   = 1'b0;
  assign clr_addr_s = {ADDR_WIDTH{1'b0}};
`endif

  // Round-robin grant: prio_r = 0 favours A, 1 favours B.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (run_s) begin
      grant_a_s = a_valid & (~b_valid | ~prio_r);
      grant_b_s = b_valid & (~a_valid |  prio_r);
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Priority pointer moves to the loser after every grant.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prio_r <= 1'b0;
    end else if (grant_a_s) begin
      prio_r <= 1'b1;
    end else if (grant_b_s) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Response tags line up with the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_resp_valid_r <= 1'b0;
      b_resp_valid_r <= 1'b0;
    end else begin
      a_resp_valid_r <= grant_a_s;
      b_resp_valid_r <= grant_b_s;
    end
  end

  // RAM port mux: sweep, winner, or idle on the last address with we low.
  always_comb begin
    ram_we_s   = 1'b0;
    ram_addr_s = last_addr_r;
    ram_d_s    = {DATA_WIDTH{1'b0}};
    if (clr_we_s) begin
      ram_we_s   = 1'b1;
      ram_addr_s = clr_addr_s;
      ram_d_s    = {DATA_WIDTH{1'b0}};
    end else if (grant_a_s) begin
      ram_we_s   = a_we;
      ram_addr_s = a_addr;
      ram_d_s    = a_data;
    end else if (grant_b_s) begin
      ram_we_s   = b_we;
      ram_addr_s = b_addr;
      ram_d_s    = b_data;
    end else begin
      ram_we_s   = 1'b0;
      ram_addr_s = last_addr_r;
    end
  end

  // Remembers the address driven to the RAM so idle cycles hold it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      last_addr_r <= ram_addr_s;
    end
  end

  sp_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .d    (ram_d_s),
    .q    (ram_q_s)
  );

  assign a_ready      = grant_a_s;
  assign b_ready      = grant_b_s;
  assign a_resp_valid = a_resp_valid_r;
  assign b_resp_valid = b_resp_valid_r;
  assign resp_data    = ram_q_s;
  assign busy         = ~run_s;

endmodule

// File: tb/tb_sp_bram_arb.sv
// Directed bench for sp_bram_arb (DATA_WIDTH=8, ADDR_WIDTH=4); sweep checks follow SP_BRAM_ARB_CLEAR_EN.

module tb_sp_bram_arb;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst_b;
  logic          a_valid;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          a_resp_valid;
  logic          b_resp_valid;
  logic [DW-1:0] resp_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  sp_bram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .a_valid      (a_valid),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .a_resp_valid (a_resp_valid),
    .b_resp_valid (b_resp_valid),
    .resp_data    (resp_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds reset for one clock edge with all requests idle, checking reset values.
  task automatic do_reset();
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0;
    rst_b = 1'b0;
    #1;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_a_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_b_resp_valid", {31'd0, b_resp_valid}, 32'd0);
`ifdef SP_BRAM_ARB_CLEAR_EN
    chk("rst_busy", {31'd0, busy}, 32'd1);
`else
    chk("rst_busy", {31'd0, busy}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  // One cycle: drive requests, check readys, clock, check the response.
  task automatic step(input string tag,
                      input logic av, input logic awe, input logic [AW-1:0] aad, input logic [DW-1:0] ad,
                      input logic bv, input logic bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bd,
                      input logic ea, input logic eb, input logic [DW-1:0] edata);
    a_valid = av; a_we = awe; a_addr = aad; a_data = ad;
    b_valid = bv; b_we = bwe; b_addr = bad; b_data = bd;
    #1;
    chk({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
    chk({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, eb});
    @(posedge clk); #1;
    chk({tag, "_a_resp_valid"}, {31'd0, a_resp_valid}, {31'd0, ea});
    chk({tag, "_b_resp_valid"}, {31'd0, b_resp_valid}, {31'd0, eb});
    if (ea || eb) chk({tag, "_resp_data"}, {24'd0, resp_data}, {24'd0, edata});
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

`ifdef SP_BRAM_ARB_CLEAR_EN
  // Counts consecutive busy cycles from reset release, bounded.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      chk({tag, "_no_ready_while_busy"}, {30'd0, a_ready, b_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, n, 32'd16);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      step(tag, 1'b1, 1'b0, AW'(i), 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h00);
    end
  endtask
`endif

  initial begin
    rst_b = 1'b0;
    #3;
    do_reset();

`ifdef SP_BRAM_ARB_CLEAR_EN
    count_busy("sweep1");
    read_all_zero("clr_rd");
`else
    chk("run_busy", {31'd0, busy}, 32'd0);
`endif

    // Write then read in the first RUN cycles; prio ends at B.
    step("wr5",  1'b1, 1'b1, 4'h5, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h11);
    step("rd5",  1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h11);
    step("wr1",  1'b1, 1'b1, 4'h1, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h11);
    step("wr2",  1'b1, 1'b1, 4'h2, 8'h22, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h22);
    step("wr3",  1'b1, 1'b1, 4'h3, 8'h5A, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h5A);
    step("brd3", 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b1, 8'h5A);

    // prio = A: contended grants alternate starting with A.
    for (int i = 0; i < 6; i++) begin
      step("alt", 1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00,
           (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 8'h11 : 8'h22);
    end

    for (int i = 0; i < 3; i++) begin
      step("bonly", 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1, 8'h22);
    end
    step("both_a", 1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0, 8'h11);
    step("both_b", 1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1, 8'h22);
    step("idle",   1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Back-to-back read-after-write to the same address.
    step("bwr4", 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h4, 8'h77, 1'b0, 1'b1, 8'h77);
    step("ard4", 1'b1, 1'b0, 4'h4, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h77);
    step("ard3", 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h5A);

    // Reset with a response pending drops it at once.
    do_reset();

`ifdef SP_BRAM_ARB_CLEAR_EN
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
    do_reset();
    count_busy("sweep2");
    read_all_zero("clr2_rd");
`else
    // Contents survive reset; prio is back at A.
    step("post_rst_both", 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 1'b0, 8'h5A);
    step("post_rst_b",    1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h4, 8'h00, 1'b0, 1'b1, 8'h77);
`endif
    step("final_idle", 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sp_bram_arb.md
# sp_bram_arb

Two-requester arbiter and sequencer in front of one single-port block RAM: it instantiates `sp_bram`, accepts one read or write per cycle from either of two requesters under round-robin arbitration, and returns read data with fixed one-cycle latency. An optional post-reset clear sweep zeroes the whole array before any requester is served. Used wherever two pipeline agents (e.g. fetch and debug/load) must share one on-chip RAM.

## Interface
- `DATA_WIDTH`, 8, word width; passed to the RAM.
- `ADDR_WIDTH`, 6, address width; RAM depth is 2**ADDR_WIDTH.

- `clk`  in  1  sole clock, rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A presents a request.
- `a_we`  in  1  A request is a write (1) or read (0).
- `a_addr`  in  ADDR_WIDTH  A address.
- `a_data`  in  DATA_WIDTH  A write data.
- `a_ready`  out  1  A request accepted this cycle (when `a_valid`).
- `b_valid`, `b_we`, `b_addr`, `b_data`, `b_ready`: same as A, for requester B.
- `a_resp_valid`  out  1  `resp_data` belongs to A's request accepted last cycle.
- `b_resp_valid`  out  1  same for B.
- `resp_data`  out  DATA_WIDTH  RAM output `q`, shared by both requesters.
- `busy`  out  1  clear sweep in progress; no requests accepted.

## Operation
- States: CLEAR (sweep) and RUN. Reset enters CLEAR when the clear sweep is configured in, RUN otherwise.
- CLEAR: a counter `clr_addr` starts at 0. Each cycle, write 0 to `clr_addr` and increment. After writing address 2**ADDR_WIDTH-1, go to RUN. `a_ready`, `b_ready` and both resp_valids are 0. `busy` is 1.
- RUN: `busy` is 0. A one-bit priority pointer `prio` selects the favoured requester and resets to A.
  - Only A valid: grant A. Only B valid: grant B. Both valid: grant the requester `prio` selects.
  - After any grant, `prio` points to the other requester. With no grant, `prio` holds.
  - `x_ready` = RUN and granted; it is combinational from the valids and `prio`. At most one ready is high per cycle.
  - A ready is never high without its valid.
- Accepted request: the RAM is driven with the winner's addr, we and data in the same cycle.
- Every accepted request, read or write, produces a response one cycle later:
  - `x_resp_valid` is high for exactly one cycle.
  - `resp_data` is the RAM `q`: the stored word for a read, the newly written word for a write.
- No response backpressure; requesters must take the response in the cycle it is valid.
- When no request is accepted, RAM `we`=0, and the address holds the last granted address. `resp_data` is don't-care while both resp_valids are 0.
- Requesters hold valid/we/addr/data stable until ready. The arbiter does not check this.

## Timing
- Reset values:
  - `a_ready`, `b_ready`, `a_resp_valid`, `b_resp_valid` = 0.
  - `busy` = 1 with clear, 0 without.
  - `prio` = A; `clr_addr` = 0.
  - `resp_data` is undefined until the first response.
- Request accepted at edge N → response valid during cycle N+1, sampled at edge N+1.
- Sustained throughput: one request per cycle. Back-to-back dependent read-after-write to the same address returns the new data.
- Both requesters valid continuously → grants alternate A, B, A, B... (A first after reset).
- Clear sweep: exactly 2**ADDR_WIDTH cycles with `busy`=1. First accept possible in the cycle after the last clear write.
- Reset asserted mid-sweep or mid-traffic aborts immediately. Any pending response is dropped (resp_valid cleared), and the sweep restarts from address 0 after release. RAM contents are not reset except by the sweep.

## Configuration
- `SP_BRAM_ARB_CLEAR_EN` defined:
  - CLEAR state, `clr_addr` counter and sweep are compiled in.
  - RAM reads all-zero after each reset.
- Undefined:
  - No CLEAR state; RUN directly from reset.
  - `busy` tied to 0.
  - RAM contents are undefined until written.

## Test plan
- Clear enabled, DATA_WIDTH=8, ADDR_WIDTH=4: release reset → `busy` high 16 cycles. Then A reads addr 0..15 → every response `resp_data`=0x00 with `a_resp_valid` one cycle after each accept.
- A writes 0x5A to addr 3 and gets response 0x5A. Next cycle B reads addr 3 → `b_resp_valid` with 0x5A.
- A and B both valid for 6 cycles (A reads addr 1, B reads addr 2) → grants A,B,A,B,A,B; responses alternate accordingly; never both readys high.
- Only B valid for 3 cycles → B granted every cycle. Then both valid → B granted first only if `prio`=B; check that `prio` follows the last grant (here A wins).
- Assert `rst_b` low at sweep address 7 for one cycle → `busy` restarts; 16 further busy cycles; addr 0..15 all read 0.
- Clear disabled → `busy`=0 from reset. A write then read at the very first RUN cycle completes with 1-cycle latency.
